// File: rtl/iter_shift_pkg.sv
// Shared types and constants for the iterative shifter.
package iter_shift_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int SHAMT_W_DEF = 3;

    // FSM encoding is kept as plain 2-bit constants so legacy code can compare raw vectors.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/iter_shift_unit_shift_step.sv
// Single-position left/right shift of a vector; the vacated MSB on a right shift takes fill.
module shift_step
    import iter_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        if (dir == DIR_LEFT)
            result = {data[WIDTH-2:0], 1'b0};
        else
            result = {fill, data[WIDTH-1:1]};
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: one bit position per clock, one-cycle done pulse on completion.
// Optional macro ITER_SHIFT_ARITH_EN adds an arith input selecting sign-filling right shifts.
module iter_shift_unit
    import iter_shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
`ifdef ITER_SHIFT_ARITH_EN
    input  logic               arith,
`endif
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [SHAMT_W-1:0] count;
    logic               dir_q;
    logic               fill;
    logic               accept;
    logic [WIDTH-1:0]   step_out;

    // DONE accepts a new request just like IDLE, which gives back-to-back throughput.
    assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef ITER_SHIFT_ARITH_EN
    logic arith_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            arith_q <= 1'b0;
        else if (accept)
            arith_q <= arith;
    end

    assign fill = arith_q & out[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data   (out),
        .dir    (dir_q),
        .fill   (fill),
        .result (step_out)
    );

    // NOTE: all state below is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            count <= '0;
            dir_q <= DIR_RIGHT;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        out   <= in;
                        count <= shamt;
                        dir_q <= dir;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        out   <= step_out;
                        count <= count - SHAMT_W'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: transaction-level model plus directed and random operations.
module tb_iter_shift_unit;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  din = '0;
    logic [SW-1:0] shamt = '0;
    logic          dir = 1'b0;
    logic          arith = 1'b0;
    logic [W-1:0]  dout;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    iter_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (din),
        .shamt (shamt),
        .dir   (dir),
`ifdef ITER_SHIFT_ARITH_EN
        .arith (arith),
`endif
        .out   (dout),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift of v by j positions as plain arithmetic.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int j,
                                               input logic d, input logic ar);
        if (d)       return v << j;
        else if (ar) return W'($signed(v) >>> j);
        else         return v >> j;
    endfunction

    // Transaction model: an op accepted at edge k finishes at edge k+shamt+1.
    int           e = 0;
    bit           pend = 1'b0;
    int           k_acc = 0;
    int           done_e = 0;
    logic [W-1:0] m_in = '0;
    int           m_sh = 0;
    logic         m_dir = 1'b0;
    logic         m_arith = 1'b0;

    always @(posedge clk) e <= e + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (start && (!pend || (e + 1 > done_e))) begin
            pend   <= 1'b1;
            k_acc  <= e + 1;
            done_e <= e + 2 + int'(shamt);
            m_in   <= din;
            m_sh   <= int'(shamt);
            m_dir  <= dir;
`ifdef ITER_SHIFT_ARITH_EN
            m_arith <= arith;
`else
            m_arith <= 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(pend && (e >= k_acc) && (e < done_e)));
            check("done", 32'(done), 32'(pend && (e == done_e)));
            check("out",  32'(dout), 32'(pend ? ref_shift(m_in, ((e - k_acc) < m_sh) ? (e - k_acc) : m_sh,
                                                         m_dir, m_arith) : '0));
        end
    end

    // Drive a request; returns #1 after the edge that samples it.
    task automatic issue(input logic [W-1:0] a, input logic [SW-1:0] s, input logic d, input logic ar);
        din = a; shamt = s; dir = d; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done; n0 is the number of edges since (and including) the sampling edge.
    task automatic wait_done(input int n0, input int s, input logic [W-1:0] exp, input string name);
        int n = n0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_edges"}, 32'(n), 32'(s + 2));
        check({name, "_out"}, 32'(dout), 32'(exp));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Abort mid-operation, then a normal run.
        issue(8'b11110011, 3'd5, 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_out", 32'(dout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        issue(8'b11110011, 3'd5, 1'b1, 1'b0);
        wait_done(1, 5, 8'b01100000, "after_abort");
        @(posedge clk); #1;

        issue(8'b11110011, 3'd1, 1'b1, 1'b0);
        wait_done(1, 1, 8'b11100110, "l1");
        @(posedge clk); #1;
        check("hold_out", 32'(dout), 32'(8'b11100110));
        issue(8'b11110011, 3'd1, 1'b0, 1'b0);
        wait_done(1, 1, 8'b01111001, "r1");
        @(posedge clk); #1;

        issue(8'b11110011, 3'd5, 1'b1, 1'b0);
        wait_done(1, 5, 8'b01100000, "l5");
        @(posedge clk); #1;
        issue(8'b11110011, 3'd5, 1'b0, 1'b0);
        wait_done(1, 5, 8'b00000111, "r5");
        @(posedge clk); #1;

        // Zero shift, then a request held through the DONE cycle.
        issue(8'b10010111, 3'd0, 1'b0, 1'b0);
        wait_done(1, 0, 8'b10010111, "z0");
        issue(8'b10010111, 3'd5, 1'b0, 1'b0);
        wait_done(1, 5, 8'b00000100, "b2b");
        @(posedge clk); #1;

        // Start while shifting must be ignored.
        issue(8'b10110001, 3'd6, 1'b1, 1'b0);
        din = 8'hff; shamt = 3'd1; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, 6, 8'b01000000, "ign");
        @(posedge clk); #1;

`ifdef ITER_SHIFT_ARITH_EN
        issue(8'b10010111, 3'd5, 1'b0, 1'b1);
        wait_done(1, 5, 8'b11111100, "asr");
        @(posedge clk); #1;
        issue(8'b10010111, 3'd5, 1'b0, 1'b0);
        wait_done(1, 5, 8'b00000100, "lsr");
        @(posedge clk); #1;
`endif

        // Every amount in both directions, then random ops with random gaps and stray starts.
        for (int t = 0; t < 60; t++) begin
            logic [W-1:0]  a;
            logic [SW-1:0] s;
            logic          d;
            logic          ar;
            int            n0;
            a  = W'($urandom);
            s  = (t < 16) ? SW'(t % 8) : SW'($urandom_range(0, 7));
            d  = (t < 16) ? 1'(t / 8) : 1'($urandom);
`ifdef ITER_SHIFT_ARITH_EN
            ar = 1'($urandom);
`else
            ar = 1'b0;
`endif
            issue(a, s, d, ar);
            n0 = 1;
            if ($urandom_range(0, 2) == 0) begin
                din = W'($urandom); shamt = SW'($urandom); dir = 1'($urandom); start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                n0 = 2;
            end
            wait_done(n0, int'(s), ref_shift(a, int'(s), d, ar), "rand");
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
